ternary_any_fold: RTL
=====================

# ternary_any_fold

Sequential reduction stage that sits directly downstream of the two-input ternary ANY operator. It accepts a stream of 2-bit-encoded trits over a valid/ready handshake and folds each packet into one trit with the ANY function. It presents the packet result, element count and an encoding-error flag on a held output handshake. The consumer can then reduce arbitrary-length trit vectors without building a combinational tree.

## Interface
- CNT_W, 8, width of the element counter; count saturates at 2^CNT_W-1
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_trit  input  2  trit encoding: 2'b00 = −, 2'b01 = 0, 2'b10 = +, 2'b11 = invalid
- in_valid  input  1  in_trit/in_last valid this cycle
- in_last  input  1  marks final trit of the packet
- in_ready  output  1  block accepts a beat this cycle
- out_trit  output  2  folded result
- out_count  output  CNT_W  number of beats accepted in the packet, invalid beats included
- out_err  output  1  at least one 2'b11 beat in the packet
- out_valid  output  1  result valid; held until taken
- out_ready  input  1  consumer takes result

## Operation
- ANY(a,b) definition:
  - a==b → a
  - one operand 0 → the other operand
  - a,b opposite (−,+) → 0
- States:
  - ACC: in_ready=1; accumulate
  - HOLD: in_ready=0; out_valid=1
- A beat is accepted when in_valid && in_ready.
- Per accepted beat in ACC:
  - t = (in_trit==2'b11) ? 2'b01 : in_trit
  - first beat of the packet (cnt==0): acc ← t; otherwise acc ← ANY(acc,t)
  - cnt ← cnt+1, saturating at all-ones
  - err ← err | (in_trit==2'b11)
- Accepted beat with in_last=1:
  - result, count and err registered into out_trit/out_count/out_err, including that beat
  - state → HOLD
- HOLD:
  - out_* held stable; in_valid ignored
  - on out_valid && out_ready: state → ACC, with acc←2'b01, cnt←0, err←0
- An invalid encoding never propagates to out_trit; out_trit is always 00, 01 or 10.
- Fold order does not change the result for same-sign or zero streams. Mixed-sign streams depend on order; the bench uses the arrival-order definition above.

## Timing
- Reset values (rst high at a clock edge):
  - state=ACC, acc=2'b01, cnt=0, err=0
  - out_trit=2'b01, out_count=0, out_err=0, out_valid=0
- in_ready is forced to 0 while rst is high. It is 1 in the first cycle after rst deasserts.
- Latency: the last beat is accepted at edge N. out_valid=1 from edge N, visible in cycle N+1.
- Minimum packet turnaround:
  - result taken at edge M
  - in_ready=1 in cycle M+1
  - there is no overlap of output hold and input accept
- Single-beat packet (in_last on the first beat): out_trit = t, out_count=1.
- Counter saturation: beats past 2^CNT_W-1 still fold into acc. out_count stays at all-ones.
- rst mid-packet or during HOLD: partial state is discarded and all outputs return to reset values on that edge. No output handshake completes.
- in_valid=0 cycles inside a packet are allowed and change nothing.
- out_ready high while out_valid=0 has no effect.

## Test plan
- Reset: hold rst 2 cycles with in_valid=1 → in_ready=0, out_valid=0, out_trit=01, out_count=0, out_err=0. Next cycle in_ready=1.
- Folding:
  - packet +,0,+(last) → out_trit=10, out_count=3, out_err=0, out_valid high in the cycle after the last accept
  - packet +,−(last) → 01
  - packet −,0,−(last) → 00
  - single-beat packet 00(last) → 00, count 1
- Backpressure: after packet 0,+(last), hold out_ready=0 for 4 cycles while pulsing in_valid → out_valid stays 1, in_ready=0, out_trit=10 and count=2 stay stable, no beats consumed. Raise out_ready → in_ready=1 the next cycle.
- Invalid encoding: packet +,11,+(last) → out_trit=10, out_count=3, out_err=1. Following packet 0(last) → out_err=0, out_trit=01.
- Saturation and gaps: CNT_W=2, send 5 beats of + with idle cycles between → out_count=3, out_trit=10.
- Reset mid-operation:
  - rst after 2 beats of a 4-beat packet → outputs at reset values. A new packet −(last) then gives 00, count 1.
  - rst during HOLD → out_valid drops on that edge.

Source files
------------

// File: rtl/ternary_any_fold.sv
// rtl/ternary_any_fold.sv - streaming ANY-fold of 2-bit trits with a held result handshake
module ternary_any_fold #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       in_trit,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [1:0]       out_trit,
    output logic [CNT_W-1:0] out_count,
    output logic             out_err,
    output logic             out_valid,
    input  logic             out_ready
);
    localparam logic [1:0]       T_ZERO  = 2'b01;
    localparam logic [1:0]       T_BAD   = 2'b11;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {ACC, HOLD} state_t;
    state_t state, state_next;

    logic [1:0]       acc;
    logic [CNT_W-1:0] cnt;
    logic             err;
    logic             accept, take;
    logic [1:0]       beat_trit, fold_trit;
    logic [CNT_W-1:0] cnt_next;
    logic             err_next;

    function automatic logic [1:0] any2(input logic [1:0] a, input logic [1:0] b);
        if (a == b)
            return a;
        else if (a == T_ZERO)
            return b;
        else if (b == T_ZERO)
            return a;
        else
            return T_ZERO;
    endfunction

    always_ff @(posedge clk) begin
        if (rst)
            state <= ACC;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ACC: begin
                in_ready = !rst;
                if (in_valid && in_last)
                    state_next = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_next = ACC;
            end
            default: state_next = ACC;
        endcase
    end

    assign accept = in_valid && in_ready;
    assign take   = out_valid && out_ready;

    // Invalid beats fold as zero so they never reach out_trit; they only set err.
    assign beat_trit = (in_trit == T_BAD) ? T_ZERO : in_trit;
    assign fold_trit = (cnt == '0) ? beat_trit : any2(acc, beat_trit);
    assign cnt_next  = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    assign err_next  = err | (in_trit == T_BAD);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= T_ZERO;
            cnt       <= '0;
            err       <= 1'b0;
            out_trit  <= T_ZERO;
            out_count <= '0;
            out_err   <= 1'b0;
        end else begin
            if (accept) begin
                acc <= fold_trit;
                cnt <= cnt_next;
                err <= err_next;
                if (in_last) begin
                    out_trit  <= fold_trit;
                    out_count <= cnt_next;
                    out_err   <= err_next;
                end
            end
            if (take) begin
                acc <= T_ZERO;
                cnt <= '0;
                err <= 1'b0;
            end
        end
    end
endmodule
